// File: rtl/mul_seq.sv
// Iterative shift-add multiplier beside the register file. It writes the
// 2*WIDTH-bit product to the register pair dst and (dst+1) mod 2^AW.
module mul_seq #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [AW-1:0]    dst,
    output logic             busy,
    output logic             done,
    output logic             Wen,
    output logic [AW-1:0]    Wd,
    output logic [WIDTH-1:0] Wdat
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WR_LO,
        WR_HI
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     dst_q, dst_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dst_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dst_q    <= dst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dst_d    = dst_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, opA};
                    mplier_d = opB;
                    dst_d    = dst;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = CALC;
                end
            end
            CALC: begin
                // No early exit: every operand costs exactly WIDTH cycles.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = WR_LO;
                end
            end
            WR_LO: state_d = WR_HI;
            WR_HI: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs come only from registered state and data.
    always_comb begin
        busy = (state_q != IDLE);
        done = 1'b0;
        Wen  = 1'b0;
        Wd   = '0;
        Wdat = '0;
        unique case (state_q)
            WR_LO: begin
                Wen  = 1'b1;
                Wd   = dst_q;
                Wdat = acc_q[WIDTH-1:0];
            end
            WR_HI: begin
                Wen  = 1'b1;
                Wd   = dst_q + AW'(1);
                Wdat = acc_q[PW-1:WIDTH];
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: a cycle-timeline model of each accepted
// request predicts every output, plus literal register-file results.
module tb_mul_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] opA = '0;
    logic [7:0] opB = '0;
    logic [2:0] dst = '0;
    logic       busy, done, Wen;
    logic [2:0] Wd;
    logic [7:0] Wdat;

    mul_seq #(.WIDTH(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .opA(opA), .opB(opB), .dst(dst),
        .busy(busy), .done(done), .Wen(Wen),
        .Wd(Wd), .Wdat(Wdat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase = cycles since the accepting edge (0 = idle).
    int         phase = 0;
    int         cyc = 0;
    int         t0 = 0;
    bit         aborted = 0;
    bit         mon_en = 0;
    logic [7:0] ma = '0, mb = '0;
    logic [2:0] md = '0;

    logic [7:0] rf [8];
    int         wr_count = 0;
    int         done_cnt = 0;
    int         busy_run = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            if (phase != 0) aborted = 1;
            phase = 0;
        end else if (phase == 0) begin
            if (start) begin
                phase = 1;
                ma = opA;
                mb = opB;
                md = dst;
                t0 = cyc;
                aborted = 0;
            end
        end else if (phase == 10) begin
            phase = 0;
        end else begin
            phase++;
        end
    end

    always @(negedge clk) begin
        logic [15:0] p;
        logic        e_busy, e_done, e_wen;
        logic [2:0]  e_wd;
        logic [7:0]  e_wdat;
        if (mon_en) begin
            p      = 16'(ma) * 16'(mb);
            e_busy = (phase != 0);
            e_done = (phase == 10);
            e_wen  = (phase == 9) || (phase == 10);
            e_wd   = (phase == 9) ? md : (phase == 10) ? 3'(md + 3'd1) : 3'd0;
            e_wdat = (phase == 9) ? p[7:0] : (phase == 10) ? p[15:8] : 8'd0;
            chk("outputs", {18'd0, busy, done, Wen, Wd, Wdat},
                {18'd0, e_busy, e_done, e_wen, e_wd, e_wdat});
            if (Wen) begin
                rf[Wd] = Wdat;
                wr_count++;
            end
            if (done) begin
                done_cnt++;
                chk("latency", cyc - t0, 9);
            end
            if (busy) begin
                busy_run++;
            end else begin
                if (busy_run != 0 && !aborted) chk("busy_len", busy_run, 10);
                busy_run = 0;
            end
        end
    end

    task automatic fill();
        for (int i = 0; i < 8; i++) rf[i] = 8'hAA;
        wr_count = 0;
        done_cnt = 0;
    endtask

    task automatic go(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] d);
        @(posedge clk);
        #1;
        start = 1'b1;
        opA = a;
        opB = b;
        dst = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        opA = 8'($urandom);
        opB = 8'($urandom);
        dst = 3'($urandom);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_wen", 32'(Wen), 0);
        chk("reset_wd_wdat", {21'd0, Wd, Wdat}, 0);

        fill();
        go(8'd13, 8'd11, 3'd2);
        repeat (12) @(posedge clk);
        chk("t1_r2", 32'(rf[2]), 32'h8F);
        chk("t1_r3", 32'(rf[3]), 32'h00);
        chk("t1_done", done_cnt, 1);

        fill();
        go(8'hFF, 8'hFF, 3'd4);
        repeat (12) @(posedge clk);
        chk("t2_r4", 32'(rf[4]), 32'h01);
        chk("t2_r5", 32'(rf[5]), 32'hFE);

        fill();
        go(8'h5A, 8'h03, 3'd7);
        repeat (12) @(posedge clk);
        chk("t3_r7", 32'(rf[7]), 32'h0E);
        chk("t3_r0", 32'(rf[0]), 32'h01);
        chk("t3_writes", wr_count, 2);

        fill();
        go(8'h20, 8'h04, 3'd1);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        opA = 8'hFF;
        opB = 8'hFF;
        dst = 3'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        chk("t4_r1", 32'(rf[1]), 32'h80);
        chk("t4_r2", 32'(rf[2]), 32'h00);
        chk("t4_r5", 32'(rf[5]), 32'hAA);
        chk("t4_r6", 32'(rf[6]), 32'hAA);
        chk("t4_writes", wr_count, 2);

        fill();
        go(8'h00, 8'h77, 3'd6);
        repeat (12) @(posedge clk);
        chk("t5_r6", 32'(rf[6]), 32'h00);
        chk("t5_r7", 32'(rf[7]), 32'h00);
        chk("t5_done", done_cnt, 1);

        fill();
        go(8'h12, 8'h34, 3'd3);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_after_rst", {18'd0, busy, done, Wen, Wd, Wdat}, 0);
        repeat (12) @(posedge clk);
        chk("t6_no_write", wr_count, 0);
        chk("t6_no_done", done_cnt, 0);
        go(8'h12, 8'h34, 3'd3);
        repeat (12) @(posedge clk);
        chk("t6_r3", 32'(rf[3]), 32'hA8);
        chk("t6_r4", 32'(rf[4]), 32'h03);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 3) == 0);
            opA   = 8'($urandom);
            opB   = 8'($urandom);
            dst   = 3'($urandom);
            rst_n = ($urandom_range(0, 79) != 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        repeat (14) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
